kpt_stream_tx: RTL and testbench
================================

KPT_STREAM_TX -- requirements
Module: kpt_stream_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning keypoint FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-004 SHALL have port kpt_valid, input, 1, meaning a keypoint record is offered.
REQ-005 SHALL have port kpt_row, input, 9, meaning keypoint row, 0..479.
REQ-006 SHALL have port kpt_col, input, 10, meaning keypoint column, 0..639.
REQ-007 SHALL have port kpt_layer, input, 1, meaning DoG layer (0 = layer1, 1 = layer2).
REQ-008 SHALL have port frame_done, input, 1, meaning single-cycle pulse marking that the detector has finished the frame.
REQ-009 SHALL have port kpt_ready, output, 1, meaning the block accepts a record this cycle.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data carries a valid word this cycle.
REQ-011 SHALL have port out_data, output, 16, meaning the output stream word; the receiver never applies backpressure.

Function
REQ-012 SHALL accept a record on a rising edge where kpt_valid = 1 and kpt_ready = 1, and SHALL write {kpt_layer, kpt_row, kpt_col} into the FIFO.
REQ-013 SHALL drive kpt_ready = 1 only when the FIFO is not full and no end-of-frame is pending, decided from registered state only.
REQ-014 SHALL leave the record unaccepted while kpt_valid = 1 and kpt_ready = 0; the producer holds it, and nothing is dropped or counted.
REQ-015 SHALL register out_valid and out_data; out_data SHALL be 16'h0000 whenever out_valid = 0.
REQ-016 SHALL implement the FSM states IDLE, W0, W1, TRL0 and TRL1; out_valid = 1 exactly in W0, W1, TRL0 and TRL1.
REQ-017 SHALL emit in W0 the word {layer, 6'b0, row[8:0]} for the FIFO head.
REQ-018 SHALL emit in W1 the word {6'b0, col[9:0]} for the FIFO head, and SHALL pop the head on leaving W1.
REQ-019 SHALL transition IDLE->W0 when the FIFO is non-empty, giving priority over the trailer.
REQ-020 SHALL transition W0->W1 unconditionally.
REQ-021 SHALL transition W1->W0 when the FIFO holds more than 1 entry before the pop, producing back-to-back words with no gap.
REQ-022 SHALL otherwise transition W1->IDLE.
REQ-023 SHALL transition IDLE->TRL0 when the FIFO is empty and eof_pending = 1.
REQ-024 SHALL emit 16'hFFFF in TRL0, then transition TRL0->TRL1.
REQ-025 SHALL emit kpt_count in TRL1, then transition TRL1->IDLE, clearing kpt_count to 0 and eof_pending to 0.
REQ-026 SHALL have latency such that a record accepted on edge k into an empty FIFO while IDLE shows word0 in the cycle after edge k+1 and word1 after edge k+2.
REQ-027 SHALL set eof_pending on a frame_done pulse; frame_done while eof_pending = 1 SHALL have no further effect (no second trailer).
REQ-028 SHALL treat a record accepted on the same edge as frame_done as part of the current frame: it is counted and transmitted before the trailer.
REQ-029 SHALL keep kpt_count as 16 bits incremented per accepted record, saturating at 16'hFFFF.
REQ-030 SHALL handle simultaneous push and pop on the same edge with a net FIFO occupancy unchanged; a push with the FIFO full is impossible by REQ-013.
REQ-031 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; full/empty SHALL be derived from an occupancy count 0..FIFO_DEPTH.
REQ-032 SHALL emit a frame with zero keypoints as just 16'hFFFF, 16'h0000.

Reset
REQ-033 SHALL, on rst = 1 at any time, immediately force state IDLE, FIFO empty, kpt_count 0, eof_pending 0, out_valid 0, out_data 16'h0000 and kpt_ready 0.
REQ-034 SHALL drive kpt_ready = 1 on the first rising edge after rst deasserts.
REQ-035 SHALL discard any partially emitted packet or trailer when reset is asserted mid-operation, and SHALL NOT resume it.

Verification
REQ-036 SHALL cover a single record: layer=1, row=479, col=639 accepted at edge k -> 16'h81DF after edge k+1, then 16'h027F, then out_valid=0.
REQ-037 SHALL cover burst fill: 9 consecutive kpt_valid cycles with FIFO_DEPTH=8 -> kpt_ready falls after the 8th acceptance if not yet drained; all accepted records appear in order as contiguous word pairs with no gaps.
REQ-038 SHALL cover end of frame: 3 records then a frame_done pulse -> 6 data words, then 16'hFFFF, then 16'h0003; a record offered while the trailer is pending sees kpt_ready=0.
REQ-039 SHALL cover the empty frame: a frame_done pulse with no records -> 16'hFFFF, 16'h0000; a second frame_done pulse during TRL0 produces no extra trailer.
REQ-040 SHALL cover the same-edge case: kpt_valid and frame_done on the same edge -> the record's two words precede the trailer, and the count includes it.
REQ-041 SHALL cover reset mid-operation: rst asserted during W1 -> out_valid=0 and out_data=0 immediately; after release the FIFO is empty and the next frame's count starts at 0.

Source files
------------

// File: rtl/kpt_stream_tx.sv
// Keypoint stream transmitter: buffers {layer,row,col} records in a small FIFO and
// serialises each as two 16-bit words, closing every frame with a 16'hFFFF + count trailer.
module kpt_stream_tx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kpt_valid,
    input  logic [8:0]  kpt_row,
    input  logic [9:0]  kpt_col,
    input  logic        kpt_layer,
    input  logic        frame_done,
    output logic        kpt_ready,
    output logic        out_valid,
    output logic [15:0] out_data
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, W0, W1, TRL0, TRL1} state_t;

    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [AW:0]   occ_reg;
    logic          run_reg;
    logic          eof_pending_reg;
    logic [15:0]   kpt_count_reg;
    state_t        state_reg, state_next;
    logic          out_valid_reg;
    logic [15:0]   out_data_reg, out_data_next;

    logic          full, empty, push, pop;
    logic [AW-1:0] head_idx;
    logic [19:0]   head;

    assign full  = (occ_reg == (AW+1)'(FIFO_DEPTH));
    assign empty = (occ_reg == '0);

    // run_reg holds ready low during reset and for the edge on which reset is released
    assign kpt_ready = run_reg & ~full & ~eof_pending_reg;
    assign push      = kpt_valid & kpt_ready;
    assign pop       = (state_reg == W1);

    // When leaving W1 the head is being popped, so the next W0 word comes from the following entry
    assign head_idx = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign head     = mem[head_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {kpt_layer, kpt_row, kpt_col};
        end
    end

    always_comb begin
        state_next    = state_reg;
        out_data_next = 16'h0000;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    state_next = W0;
                end else if (eof_pending_reg) begin
                    state_next = TRL0;
                end
            end
            W0:      state_next = W1;
            W1:      state_next = (occ_reg > (AW+1)'(1)) ? W0 : IDLE;
            TRL0:    state_next = TRL1;
            TRL1:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        case (state_next)
            W0:      out_data_next = {head[19], 6'b0, head[18:10]};
            W1:      out_data_next = {6'b0, head[9:0]};
            TRL0:    out_data_next = 16'hFFFF;
            TRL1:    out_data_next = kpt_count_reg;
            default: out_data_next = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            occ_reg         <= '0;
            run_reg         <= 1'b0;
            eof_pending_reg <= 1'b0;
            kpt_count_reg   <= 16'h0000;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= 16'h0000;
        end else begin
            run_reg       <= 1'b1;
            state_reg     <= state_next;
            out_valid_reg <= (state_next != IDLE);
            out_data_reg  <= out_data_next;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
                2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
                default: occ_reg <= occ_reg;
            endcase

            // No record can be accepted while the trailer is pending, so clearing here loses nothing
            if (state_reg == TRL1) begin
                kpt_count_reg   <= 16'h0000;
                eof_pending_reg <= 1'b0;
            end else begin
                if (push && kpt_count_reg != 16'hFFFF) begin
                    kpt_count_reg <= kpt_count_reg + 16'h0001;
                end
                if (frame_done) begin
                    eof_pending_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_kpt_stream_tx.sv
// Directed bench for kpt_stream_tx: single record, burst fill, trailers, same-edge frame end,
// and reset in the middle of a packet.
module tb_kpt_stream_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kpt_valid = 1'b0;
    logic [8:0]  kpt_row = '0;
    logic [9:0]  kpt_col = '0;
    logic        kpt_layer = 1'b0;
    logic        frame_done = 1'b0;
    logic        kpt_ready;
    logic        out_valid;
    logic [15:0] out_data;

    int          checks = 0;
    int          errors = 0;
    int          gaps = 0;
    logic        prev_v = 1'b0;
    logic [15:0] q[$];
    logic [15:0] exp_q[$];

    kpt_stream_tx #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .kpt_valid(kpt_valid), .kpt_row(kpt_row), .kpt_col(kpt_col),
        .kpt_layer(kpt_layer), .frame_done(frame_done), .kpt_ready(kpt_ready),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock, then capture the registered output stream
    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (!prev_v && q.size() > 0) gaps++;
            q.push_back(out_data);
        end
        prev_v = out_valid;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic l, input logic [8:0] r, input logic [9:0] c);
        kpt_valid = 1'b1;
        kpt_layer = l;
        kpt_row   = r;
        kpt_col   = c;
    endtask

    function automatic logic [15:0] w0(input logic l, input logic [8:0] r);
        return {l, 6'b0, r};
    endfunction

    function automatic logic [15:0] w1(input logic [9:0] c);
        return {6'b0, c};
    endfunction

    task automatic cmp_queue(input string tag);
        chk({tag, "_len"}, q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), q[i], exp_q[i]);
        q.delete();
        exp_q.delete();
        gaps = 0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    initial begin
        int   acc;
        int   full_at;
        logic r;

        // Reset state
        #2;
        chk("rst_ready", kpt_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        #20 rst = 1'b0;
        #1;
        chk("release_ready_before_edge", kpt_ready, 1'b0);
        step();
        chk("release_ready_after_edge", kpt_ready, 1'b1);

        // Single record: layer 1, row 479, col 639
        offer(1'b1, 9'd479, 10'd639);
        step();
        kpt_valid = 1'b0;
        chk("single_accept_cycle_valid", out_valid, 1'b0);
        step();
        chk("single_w0_valid", out_valid, 1'b1);
        chk("single_w0_data", out_data, 16'h81DF);
        step();
        chk("single_w1_valid", out_valid, 1'b1);
        chk("single_w1_data", out_data, 16'h027F);
        step();
        chk("single_after_valid", out_valid, 1'b0);
        chk("single_after_data", out_data, 16'h0000);
        q.delete();
        gaps = 0;

        // Burst of 16 offers with the producer holding while not ready
        acc = 0;
        full_at = -1;
        for (int n = 0; n < 200 && acc < 16; n++) begin
            offer(acc[0], 9'(acc * 7), 10'(acc * 13 + 1));
            r = kpt_ready;
            step();
            if (r) begin
                acc++;
                if (full_at < 0 && !kpt_ready) full_at = acc;
            end
        end
        kpt_valid = 1'b0;
        chk("burst_accepted", acc, 16);
        chk("burst_full_at", full_at, 13);
        steps(40);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(w0(i[0], 9'(i * 7)));
            exp_q.push_back(w1(10'(i * 13 + 1)));
        end
        chk("burst_gaps", gaps, 0);
        cmp_queue("burst");

        // Trailer for the frame so far: 1 + 16 records
        pulse_done();
        chk("eof_ready_low", kpt_ready, 1'b0);
        steps(8);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0011);
        cmp_queue("trailer17");
        chk("after_trailer_ready", kpt_ready, 1'b1);

        // Three records then end of frame; an offer while pending is refused
        offer(1'b0, 9'd10, 10'd20);
        step();
        offer(1'b1, 9'd11, 10'd21);
        step();
        offer(1'b0, 9'd12, 10'd22);
        step();
        kpt_valid = 1'b0;
        pulse_done();
        offer(1'b1, 9'd100, 10'd200);
        #1;
        chk("pending_offer_ready", kpt_ready, 1'b0);
        step();
        chk("pending_offer_ready2", kpt_ready, 1'b0);
        kpt_valid = 1'b0;
        steps(12);
        exp_q.push_back(w0(1'b0, 9'd10));
        exp_q.push_back(w1(10'd20));
        exp_q.push_back(w0(1'b1, 9'd11));
        exp_q.push_back(w1(10'd21));
        exp_q.push_back(w0(1'b0, 9'd12));
        exp_q.push_back(w1(10'd22));
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0003);
        cmp_queue("eof3");

        // Empty frame with a second frame_done during TRL0
        pulse_done();
        step();
        chk("empty_trl0_data", out_data, 16'hFFFF);
        pulse_done();
        chk("empty_trl1_data", out_data, 16'h0000);
        chk("empty_trl1_valid", out_valid, 1'b1);
        steps(8);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        cmp_queue("empty");

        // Record and frame_done on the same edge
        offer(1'b0, 9'd5, 10'd6);
        frame_done = 1'b1;
        step();
        kpt_valid  = 1'b0;
        frame_done = 1'b0;
        steps(10);
        exp_q.push_back(16'h0005);
        exp_q.push_back(16'h0006);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0001);
        cmp_queue("same_edge");

        // Reset while the first of two records is in W1
        offer(1'b1, 9'd300, 10'd400);
        step();
        offer(1'b0, 9'd301, 10'd401);
        step();
        kpt_valid = 1'b0;
        step();
        chk("mid_w1_data", out_data, w1(10'd400));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 16'h0000);
        chk("mid_rst_ready", kpt_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        gaps = 0;
        prev_v = 1'b0;
        step();
        chk("mid_release_ready", kpt_ready, 1'b1);
        steps(6);
        chk("mid_no_resume", q.size(), 0);
        pulse_done();
        steps(8);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        cmp_queue("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
